// File: rtl/conv_tile_pkg.sv
// Shared types and derived-count helpers for the RepVGG conv tile sequencer.
package conv_tile_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_IFM,
        LD_WHT,
        MAC,
        PSUM_RD,
        WB,
        DONE
    } state_t;

    function automatic int unsigned calc_wp(int unsigned w, int unsigned pad);
        return w + 2 * pad;
    endfunction

    function automatic int unsigned calc_ow(int unsigned wp, int unsigned k);
        return wp - k + 1;
    endfunction

    function automatic int unsigned calc_ifm_beats(int unsigned wp, int unsigned k,
                                                   int unsigned pe_cols);
        return wp * (k + pe_cols - 1);
    endfunction

    function automatic int unsigned calc_wht_beats(int unsigned k, int unsigned kn);
        return k * k * kn;
    endfunction

    function automatic int unsigned calc_wb_beats(int unsigned pe_cols, int unsigned kn);
        return pe_cols * kn;
    endfunction

endpackage

// File: rtl/conv_tile_seq_if.sv
// Stream handshakes between the tile sequencer and the DMA / SRAM side.
interface conv_tile_seq_if;
    logic ifm_valid;
    logic ifm_ready;
    logic wht_valid;
    logic wht_ready;
    logic psum_rd_valid;
    logic psum_rd_ready;
    logic wb_valid;
    logic wb_ready;

    modport master (
        input  ifm_valid, wht_valid, psum_rd_ready, wb_ready,
        output ifm_ready, wht_ready, psum_rd_valid, wb_valid
    );

    modport slave (
        output ifm_valid, wht_valid, psum_rd_ready, wb_ready,
        input  ifm_ready, wht_ready, psum_rd_valid, wb_valid
    );
endinterface

// File: rtl/conv_tile_addr_gen.sv
// Counter and SRAM address datapath for the conv tile sequencer; advanced by FSM strobes.
module conv_tile_addr_gen
    import conv_tile_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int PE_COLS     = 8,
    parameter int KERNEL_NUM  = 2,
    parameter int GRP_W       = 6,
    parameter int AW          = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             ld_inc,
    input  logic             ld_wht,
    input  logic             mac_inc,
    input  logic             xfer_inc,
    input  logic             col_inc,
    input  logic             grp_inc,
    input  logic             sel_ifm_ld,
    input  logic             sel_wht_ld,
    input  logic             sel_mac,
    input  logic [AW-1:0]    wp,
    input  logic [AW-1:0]    ow,
    input  logic [AW-1:0]    ifm_beats,
    input  logic [GRP_W-1:0] grps,
    output logic             ld_last,
    output logic             mac_first,
    output logic             mac_last,
    output logic             xfer_last,
    output logic             col_last,
    output logic             grp_last,
    output logic             grp_zero,
    output logic [AW-1:0]    ifm_addr,
    output logic [AW-1:0]    wht_addr,
    output logic [AW-1:0]    psum_addr
);

    localparam int WHT_BEATS = calc_wht_beats(KERNEL_SIZE, KERNEL_NUM);
    localparam int WB_BEATS  = calc_wb_beats(PE_COLS, KERNEL_NUM);
    localparam int KW        = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int XW        = (WB_BEATS > 1) ? $clog2(WB_BEATS) : 1;
    localparam logic [KW-1:0] K_LAST   = KW'(KERNEL_SIZE - 1);
    localparam logic [XW-1:0] X_LAST   = XW'(WB_BEATS - 1);
    localparam logic [AW-1:0] WHT_LAST = AW'(WHT_BEATS - 1);

    logic [AW-1:0]    ld_beat;
    logic [KW-1:0]    k_row;
    logic [KW-1:0]    k_col;
    logic [XW-1:0]    xfer_beat;
    logic [AW-1:0]    col;
    logic [GRP_W-1:0] grp;

    always_comb begin
        ld_last   = ld_wht ? (ld_beat == WHT_LAST) : (ld_beat == ifm_beats - AW'(1));
        mac_first = (k_row == '0) && (k_col == '0);
        mac_last  = (k_row == K_LAST) && (k_col == K_LAST);
        xfer_last = (xfer_beat == X_LAST);
        col_last  = (col == ow - AW'(1));
        grp_last  = (grp == grps - GRP_W'(1));
        grp_zero  = (grp == '0);
    end

    // Every counter wraps on its terminal beat in the same cycle the FSM moves on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_beat   <= '0;
            k_row     <= '0;
            k_col     <= '0;
            xfer_beat <= '0;
            col       <= '0;
            grp       <= '0;
        end else if (clr) begin
            ld_beat   <= '0;
            k_row     <= '0;
            k_col     <= '0;
            xfer_beat <= '0;
            col       <= '0;
            grp       <= '0;
        end else begin
            if (ld_inc)
                ld_beat <= ld_last ? '0 : ld_beat + AW'(1);
            if (mac_inc) begin
                if (k_col == K_LAST) begin
                    k_col <= '0;
                    k_row <= (k_row == K_LAST) ? '0 : k_row + KW'(1);
                end else begin
                    k_col <= k_col + KW'(1);
                end
            end
            if (xfer_inc)
                xfer_beat <= xfer_last ? '0 : xfer_beat + XW'(1);
            if (col_inc)
                col <= col_last ? '0 : col + AW'(1);
            if (grp_inc)
                grp <= grp_last ? '0 : grp + GRP_W'(1);
        end
    end

    always_comb begin
        ifm_addr = '0;
        if (sel_ifm_ld)
            ifm_addr = ld_beat;
        else if (sel_mac)
            ifm_addr = col + AW'(k_row) * wp + AW'(k_col);
        wht_addr  = sel_wht_ld ? ld_beat
                               : AW'(k_row) * AW'(KERNEL_SIZE) + AW'(k_col);
        psum_addr = col * AW'(WB_BEATS) + AW'(xfer_beat);
    end

endmodule

// File: rtl/conv_tile_seq.sv
// RepVGG conv PE-array tile sequencer with runtime IFM width / group count.
// Optional busy/stall performance counters when CONV_TILE_PERF_EN is defined.
module conv_tile_seq
    import conv_tile_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int PAD         = 1,
    parameter int PE_COLS     = 8,
    parameter int KERNEL_NUM  = 2,
    parameter int MAX_IFM_W   = 56,
    parameter int GRP_W       = 6,
    parameter int AW          = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       cfg_ifm_w,
    input  logic [GRP_W-1:0] cfg_grps,
    conv_tile_seq_if.master  sif,
    output logic             pe_en,
    output logic             pe_acc_rst,
    output logic [AW-1:0]    ifm_addr,
    output logic [AW-1:0]    wht_addr,
    output logic [AW-1:0]    psum_addr,
    output logic             busy,
    output logic             done
`ifdef CONV_TILE_PERF_EN
    ,
    output logic [31:0]      perf_cycles,
    output logic [31:0]      perf_stalls
`endif
);

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       w_q;
    logic [GRP_W-1:0] grps_q;
    logic [AW-1:0]    wp;
    logic [AW-1:0]    ow;
    logic [AW-1:0]    ifm_beats;
    logic             start_acc;

    logic ld_inc, mac_inc, xfer_inc, col_inc, grp_inc;
    logic ld_last, mac_first, mac_last, xfer_last, col_last, grp_last, grp_zero;

    assign start_acc = start && !abort && (state == IDLE);

    // Config is sampled only on an accepted start; a zero group count runs as one group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q    <= '0;
            grps_q <= '0;
        end else if (start_acc) begin
            w_q    <= cfg_ifm_w;
            grps_q <= (cfg_grps == '0) ? GRP_W'(1) : cfg_grps;
        end
    end

    assign wp        = AW'(calc_wp(32'(w_q), PAD));
    assign ow        = AW'(calc_ow(32'(wp), KERNEL_SIZE));
    assign ifm_beats = AW'(calc_ifm_beats(32'(wp), KERNEL_SIZE, PE_COLS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)                             state_nxt = LD_IFM;
            LD_IFM:  if (sif.ifm_valid && ld_last)          state_nxt = LD_WHT;
            LD_WHT:  if (sif.wht_valid && ld_last)          state_nxt = MAC;
            MAC:     if (mac_last)                          state_nxt = grp_zero ? WB : PSUM_RD;
            PSUM_RD: if (sif.psum_rd_ready && xfer_last)    state_nxt = WB;
            WB: begin
                if (sif.wb_ready && xfer_last) begin
                    if (!col_last)     state_nxt = MAC;
                    else if (grp_last) state_nxt = DONE;
                    else               state_nxt = LD_IFM;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort)
            state_nxt = IDLE;
    end

    always_comb begin
        sif.ifm_ready     = (state == LD_IFM);
        sif.wht_ready     = (state == LD_WHT);
        sif.psum_rd_valid = (state == PSUM_RD);
        sif.wb_valid      = (state == WB);
        pe_en             = (state == MAC);
        pe_acc_rst        = (state == MAC) && mac_first;
        busy              = (state != IDLE);
        done              = (state == DONE);
        ld_inc   = ((state == LD_IFM) && sif.ifm_valid) || ((state == LD_WHT) && sif.wht_valid);
        mac_inc  = (state == MAC);
        xfer_inc = ((state == PSUM_RD) && sif.psum_rd_ready) || ((state == WB) && sif.wb_ready);
        col_inc  = (state == WB) && sif.wb_ready && xfer_last;
        grp_inc  = col_inc && col_last;
    end

    conv_tile_addr_gen #(
        .KERNEL_SIZE (KERNEL_SIZE),
        .PE_COLS     (PE_COLS),
        .KERNEL_NUM  (KERNEL_NUM),
        .GRP_W       (GRP_W),
        .AW          (AW)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (abort),
        .ld_inc     (ld_inc),
        .ld_wht     (state == LD_WHT),
        .mac_inc    (mac_inc),
        .xfer_inc   (xfer_inc),
        .col_inc    (col_inc),
        .grp_inc    (grp_inc),
        .sel_ifm_ld (state == LD_IFM),
        .sel_wht_ld (state == LD_WHT),
        .sel_mac    (state == MAC),
        .wp         (wp),
        .ow         (ow),
        .ifm_beats  (ifm_beats),
        .grps       (grps_q),
        .ld_last    (ld_last),
        .mac_first  (mac_first),
        .mac_last   (mac_last),
        .xfer_last  (xfer_last),
        .col_last   (col_last),
        .grp_last   (grp_last),
        .grp_zero   (grp_zero),
        .ifm_addr   (ifm_addr),
        .wht_addr   (wht_addr),
        .psum_addr  (psum_addr)
    );

`ifdef CONV_TILE_PERF_EN
    logic stall_now;

    always_comb begin
        stall_now = 1'b0;
        case (state)
            LD_IFM:  stall_now = sif.ifm_valid ^ sif.ifm_ready;
            LD_WHT:  stall_now = sif.wht_valid ^ sif.wht_ready;
            PSUM_RD: stall_now = sif.psum_rd_valid ^ sif.psum_rd_ready;
            WB:      stall_now = sif.wb_valid ^ sif.wb_ready;
            default: stall_now = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if (abort || start_acc) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else begin
            if (busy && !(&perf_cycles))
                perf_cycles <= perf_cycles + 32'd1;
            if (stall_now && !(&perf_stalls))
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_tile_seq.sv
// Directed self-checking bench for conv_tile_seq (default parameters).
module tb_conv_tile_seq;

    localparam int AW    = 14;
    localparam int GRP_W = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [7:0]       cfg_ifm_w;
    logic [GRP_W-1:0] cfg_grps;
    logic             pe_en, pe_acc_rst, busy, done;
    logic [AW-1:0]    ifm_addr, wht_addr, psum_addr;
`ifdef CONV_TILE_PERF_EN
    logic [31:0]      perf_cycles, perf_stalls;
`endif

    conv_tile_seq_if bus ();

    conv_tile_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .cfg_ifm_w  (cfg_ifm_w),
        .cfg_grps   (cfg_grps),
        .sif        (bus),
        .pe_en      (pe_en),
        .pe_acc_rst (pe_acc_rst),
        .ifm_addr   (ifm_addr),
        .wht_addr   (wht_addr),
        .psum_addr  (psum_addr),
        .busy       (busy),
        .done       (done)
`ifdef CONV_TILE_PERF_EN
        ,
        .perf_cycles(perf_cycles),
        .perf_stalls(perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int npass = 0;

    // Event counters and an independent address model, sampled on the falling edge.
    int mon_wp, mon_ow, mon_ifmb;
    int mon_busy, mon_ifm, mon_wht, mon_mac, mon_acc, mon_psum, mon_wb, mon_done;
    int mon_bad_ld, mon_bad_mac, mon_bad_psum, max_psum, max_ifm_mac;
    int mi, mc;
    logic [31:0] me;

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) mon_busy <= mon_busy + 1;
            if (done) mon_done <= mon_done + 1;
            if (bus.ifm_valid && bus.ifm_ready) begin
                if (ifm_addr !== AW'(mon_ifm % mon_ifmb)) mon_bad_ld <= mon_bad_ld + 1;
                mon_ifm <= mon_ifm + 1;
            end
            if (bus.wht_valid && bus.wht_ready) begin
                if (wht_addr !== AW'(mon_wht % 18)) mon_bad_ld <= mon_bad_ld + 1;
                mon_wht <= mon_wht + 1;
            end
            if (pe_en) begin
                mi = mon_mac % 9;
                mc = (mon_mac / 9) % mon_ow;
                me = 32'(mc + (mi / 3) * mon_wp + (mi % 3));
                if (ifm_addr !== me[AW-1:0] || wht_addr !== AW'(mi) || pe_acc_rst !== (mi == 0))
                    mon_bad_mac <= mon_bad_mac + 1;
                if (pe_acc_rst) mon_acc <= mon_acc + 1;
                if (int'(ifm_addr) > max_ifm_mac) max_ifm_mac <= int'(ifm_addr);
                mon_mac <= mon_mac + 1;
            end
            if (bus.psum_rd_valid && bus.psum_rd_ready) begin
                if (psum_addr !== AW'(mon_psum % (mon_ow * 16))) mon_bad_psum <= mon_bad_psum + 1;
                mon_psum <= mon_psum + 1;
            end
            if (bus.wb_valid && bus.wb_ready) begin
                if (psum_addr !== AW'(mon_wb % (mon_ow * 16))) mon_bad_psum <= mon_bad_psum + 1;
                if (int'(psum_addr) > max_psum) max_psum <= int'(psum_addr);
                mon_wb <= mon_wb + 1;
            end
        end
    end

    task automatic clear_mon(input int w);
        mon_wp = w + 2; mon_ow = w; mon_ifmb = (w + 2) * 10;
        mon_busy = 0; mon_ifm = 0; mon_wht = 0; mon_mac = 0; mon_acc = 0;
        mon_psum = 0; mon_wb = 0; mon_done = 0;
        mon_bad_ld = 0; mon_bad_mac = 0; mon_bad_psum = 0; max_psum = 0; max_ifm_mac = 0;
    endtask

    task automatic start_job(input int w, input int g);
        cfg_ifm_w = 8'(w);
        cfg_grps  = GRP_W'(g);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < budget) begin
            @(posedge clk); #1;
            n++;
            if (done) seen = 1'b1;
        end
        timed_out = !seen;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_ifm_w = 8'd4; cfg_grps = '0;
        bus.ifm_valid = 1'b1; bus.wht_valid = 1'b1; bus.psum_rd_ready = 1'b1; bus.wb_ready = 1'b1;
        clear_mon(4);
        repeat (3) @(posedge clk);
        #1;
        nchk++; if ({busy, done, pe_en, pe_acc_rst} !== 4'b0) $display("FAIL reset_ctrl: got %b want 0000", {busy, done, pe_en, pe_acc_rst}); else npass++;
        nchk++; if ({bus.ifm_ready, bus.wht_ready, bus.psum_rd_valid, bus.wb_valid} !== 4'b0) $display("FAIL reset_hs: got %b want 0000", {bus.ifm_ready, bus.wht_ready, bus.psum_rd_valid, bus.wb_valid}); else npass++;
        nchk++; if ({ifm_addr, wht_addr, psum_addr} !== '0) $display("FAIL reset_addr: got %h/%h/%h want 0", ifm_addr, wht_addr, psum_addr); else npass++;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        nchk++; if (busy !== 1'b0) $display("FAIL idle_after_reset: busy=%b want 0", busy); else npass++;
    endtask

    task automatic test_single_group();
        bit to;
        clear_mon(4);
        start_job(4, 1);
        wait_done(1000, to);
        nchk++; if (to) $display("FAIL g1_timeout: done not seen"); else npass++;
        nchk++; if (mon_busy !== 179) $display("FAIL g1_busy: got %0d want 179", mon_busy); else npass++;
        nchk++; if (mon_ifm !== 60 || mon_wht !== 18) $display("FAIL g1_loads: got %0d/%0d want 60/18", mon_ifm, mon_wht); else npass++;
        nchk++; if (mon_mac !== 36 || mon_acc !== 4) $display("FAIL g1_mac: got %0d/%0d want 36/4", mon_mac, mon_acc); else npass++;
        nchk++; if (mon_psum !== 0 || mon_wb !== 64) $display("FAIL g1_xfer: got %0d/%0d want 0/64", mon_psum, mon_wb); else npass++;
        nchk++; if (mon_done !== 1) $display("FAIL g1_done: got %0d want 1", mon_done); else npass++;
        nchk++; if (mon_bad_ld !== 0 || mon_bad_mac !== 0 || mon_bad_psum !== 0) $display("FAIL g1_addr: bad ld/mac/psum %0d/%0d/%0d want 0", mon_bad_ld, mon_bad_mac, mon_bad_psum); else npass++;
        nchk++; if (max_psum !== 63) $display("FAIL g1_max_psum: got %0d want 63", max_psum); else npass++;
        nchk++; if (busy !== 1'b0) $display("FAIL g1_idle: busy=%b want 0", busy); else npass++;
    endtask

    task automatic test_two_groups();
        bit to;
        clear_mon(4);
        start_job(4, 2);
        wait_done(2000, to);
        nchk++; if (to) $display("FAIL g2_timeout: done not seen"); else npass++;
        nchk++; if (mon_busy !== 421) $display("FAIL g2_busy: got %0d want 421", mon_busy); else npass++;
        nchk++; if (mon_ifm !== 120 || mon_wht !== 36) $display("FAIL g2_loads: got %0d/%0d want 120/36", mon_ifm, mon_wht); else npass++;
        nchk++; if (mon_psum !== 64 || mon_wb !== 128) $display("FAIL g2_xfer: got %0d/%0d want 64/128", mon_psum, mon_wb); else npass++;
        nchk++; if (mon_done !== 1) $display("FAIL g2_done: got %0d want 1", mon_done); else npass++;
        nchk++; if (mon_bad_ld !== 0 || mon_bad_mac !== 0 || mon_bad_psum !== 0) $display("FAIL g2_addr: bad ld/mac/psum %0d/%0d/%0d want 0", mon_bad_ld, mon_bad_mac, mon_bad_psum); else npass++;
    endtask

    task automatic test_wb_stall();
        bit to;
        int n = 0;
        clear_mon(4);
        start_job(4, 1);
        while (!(bus.wb_valid && mon_wb == 5) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        nchk++; if (n >= 500) $display("FAIL stall_reach: wb beat 5 not reached"); else npass++;
        bus.wb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            nchk++; if (bus.wb_valid !== 1'b1 || psum_addr !== AW'(5)) $display("FAIL stall_hold%0d: wb_valid=%b psum_addr=%0d want 1/5", i, bus.wb_valid, psum_addr); else npass++;
        end
        bus.wb_ready = 1'b1;
        wait_done(1000, to);
        nchk++; if (to) $display("FAIL stall_timeout: done not seen"); else npass++;
        nchk++; if (mon_busy !== 184) $display("FAIL stall_busy: got %0d want 184", mon_busy); else npass++;
        nchk++; if (mon_wb !== 64 || mon_bad_psum !== 0) $display("FAIL stall_wb: beats %0d bad %0d want 64/0", mon_wb, mon_bad_psum); else npass++;
`ifdef CONV_TILE_PERF_EN
        nchk++; if (perf_cycles !== 32'd184 || perf_stalls !== 32'd5) $display("FAIL stall_perf: got %0d/%0d want 184/5", perf_cycles, perf_stalls); else npass++;
`endif
    endtask

    task automatic test_abort();
        bit to;
        int n = 0;
        clear_mon(4);
        start_job(4, 1);
        while (!(pe_en && mon_mac == 21) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        nchk++; if (n >= 500 || ifm_addr !== AW'(8)) $display("FAIL abort_reach: ifm_addr=%0d want 8", ifm_addr); else npass++;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        nchk++; if ({busy, done, pe_en, pe_acc_rst, bus.ifm_ready, bus.wb_valid} !== 6'b0) $display("FAIL abort_ctrl: got %b want 000000", {busy, done, pe_en, pe_acc_rst, bus.ifm_ready, bus.wb_valid}); else npass++;
        nchk++; if ({ifm_addr, wht_addr, psum_addr} !== '0) $display("FAIL abort_addr: got %0d/%0d/%0d want 0", ifm_addr, wht_addr, psum_addr); else npass++;
        cfg_ifm_w = 8'd4; cfg_grps = GRP_W'(1);
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        nchk++; if (busy !== 1'b0) $display("FAIL abort_start: busy=%b want 0", busy); else npass++;
        clear_mon(4);
        start_job(4, 1);
        wait_done(1000, to);
        nchk++; if (to || mon_busy !== 179 || mon_done !== 1) $display("FAIL abort_rerun: timeout=%b busy=%0d done=%0d want 0/179/1", to, mon_busy, mon_done); else npass++;
        nchk++; if (mon_bad_mac !== 0 || mon_bad_psum !== 0) $display("FAIL abort_rerun_addr: bad mac/psum %0d/%0d want 0", mon_bad_mac, mon_bad_psum); else npass++;
    endtask

    task automatic test_start_busy_g0();
        bit to;
        clear_mon(4);
        start_job(4, 0);
        repeat (10) @(posedge clk);
        #1;
        cfg_ifm_w = 8'd8; cfg_grps = GRP_W'(3);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1000, to);
        nchk++; if (to) $display("FAIL cfg_timeout: done not seen"); else npass++;
        nchk++; if (mon_busy !== 179 || mon_ifm !== 60) $display("FAIL cfg_latched: busy=%0d ifm=%0d want 179/60", mon_busy, mon_ifm); else npass++;
        nchk++; if (mon_psum !== 0 || mon_done !== 1) $display("FAIL cfg_g0: psum=%0d done=%0d want 0/1", mon_psum, mon_done); else npass++;
        nchk++; if (mon_bad_ld !== 0 || mon_bad_mac !== 0) $display("FAIL cfg_addr: bad ld/mac %0d/%0d want 0", mon_bad_ld, mon_bad_mac); else npass++;
    endtask

    task automatic test_max_width();
        bit to;
        clear_mon(56);
        start_job(56, 3);
        wait_done(10000, to);
        nchk++; if (to) $display("FAIL max_timeout: done not seen"); else npass++;
        nchk++; if (mon_busy !== 7787) $display("FAIL max_busy: got %0d want 7787", mon_busy); else npass++;
        nchk++; if (mon_ifm !== 1740 || mon_wht !== 54) $display("FAIL max_loads: got %0d/%0d want 1740/54", mon_ifm, mon_wht); else npass++;
        nchk++; if (mon_mac !== 1512 || mon_acc !== 168) $display("FAIL max_mac: got %0d/%0d want 1512/168", mon_mac, mon_acc); else npass++;
        nchk++; if (mon_psum !== 1792 || mon_wb !== 2688) $display("FAIL max_xfer: got %0d/%0d want 1792/2688", mon_psum, mon_wb); else npass++;
        nchk++; if (mon_bad_ld !== 0 || mon_bad_mac !== 0 || mon_bad_psum !== 0) $display("FAIL max_addr: bad ld/mac/psum %0d/%0d/%0d want 0", mon_bad_ld, mon_bad_mac, mon_bad_psum); else npass++;
        nchk++; if (max_psum !== 895 || max_ifm_mac !== 173) $display("FAIL max_peak: psum %0d ifm %0d want 895/173", max_psum, max_ifm_mac); else npass++;
        nchk++; if (mon_done !== 1) $display("FAIL max_done: got %0d want 1", mon_done); else npass++;
`ifdef CONV_TILE_PERF_EN
        nchk++; if (perf_cycles !== 32'd7787 || perf_stalls !== 32'd0) $display("FAIL max_perf: got %0d/%0d want 7787/0", perf_cycles, perf_stalls); else npass++;
`endif
    endtask

    initial begin
        test_reset();
        test_single_group();
        test_two_groups();
        test_wb_stall();
        test_abort();
        test_start_busy_g0();
        test_max_width();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
